ndp_axis_unpacker: RTL

Front-end stage of the NDP core: it sits directly between the 32-bit AXI-Stream slave port and the systolic-array feeder. It deserializes the interleaved input stream into matched vector pairs for the array. Each pair is one activation column (ROWS elements) followed by one weight row (COLS elements). Each pair is presented to the feeder as a single parallel vector with a valid/ready handshake, tagged with its reduction-step index and a last flag.

---
 rtl/ndp_pkg.sv | 31 +++
 rtl/ndp_beat_collect.sv | 39 +++
 rtl/ndp_axis_unpacker.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ndp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ndp_pkg
// Purpose  : Shared types and derived constants for the NDP AXI-Stream unpacker.
// Revision : 1.0
// ============================================================================
package ndp_pkg;

  localparam int NDP_WIDTH  = 16;
  localparam int NDP_ROWS   = 4;
  localparam int NDP_COLS   = 64;
  localparam int NDP_AXIS_W = 32;

  localparam int EPB        = NDP_AXIS_W / NDP_WIDTH;
  localparam int ACT_BEATS  = NDP_ROWS / EPB;
  localparam int WGT_BEATS  = NDP_COLS / EPB;
  localparam int BEAT_CNT_W = $clog2(WGT_BEATS);

  typedef enum logic [1:0] {
    S_ACT  = 2'd0,
    S_WGT  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // A counter over a single beat still needs one bit.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ndp_beat_collect.sv
`default_nettype none
// ============================================================================
// Module   : ndp_beat_collect
// Purpose  : Beat-indexed register bank; writes one stream beat per slot.
// Revision : 1.0
// ============================================================================
module ndp_beat_collect
  import ndp_pkg::*;
#(
  parameter int BEATS  = ACT_BEATS,
  parameter int AXIS_W = NDP_AXIS_W,
  parameter int CNT_W  = BEAT_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_we,
  input  logic [CNT_W-1:0]        i_idx,
  input  logic [AXIS_W-1:0]       i_data,
  output logic [BEATS*AXIS_W-1:0] o_vec
);

  generate
    for (genvar b = 0; b < BEATS; b++) begin : g_slot
      logic [AXIS_W-1:0] r_slot;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_slot <= '0;
        end else if (i_we && (i_idx == CNT_W'(b))) begin
          r_slot <= i_data;
        end
      end

      assign o_vec[b*AXIS_W +: AXIS_W] = r_slot;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/ndp_axis_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : ndp_axis_unpacker
// Purpose  : Deserializes the AXI-Stream input into activation/weight vector
//            pairs for the systolic-array feeder. NDP_TLAST_CHECK_EN enables
//            early-tlast detection and the sticky proto_err output.
// Revision : 1.0
// ============================================================================
module ndp_axis_unpacker
  import ndp_pkg::*;
#(
  parameter int WIDTH  = NDP_WIDTH,
  parameter int ROWS   = NDP_ROWS,
  parameter int COLS   = NDP_COLS,
  parameter int AXIS_W = NDP_AXIS_W,
  parameter int K_W    = 16
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic [AXIS_W-1:0]     s_axis_tdata,
  input  logic                  s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [ROWS*WIDTH-1:0] act_vec,
  output logic [COLS*WIDTH-1:0] wgt_vec,
  output logic                  vec_valid,
  input  logic                  vec_ready,
  output logic [K_W-1:0]        vec_k,
  output logic                  vec_last
`ifdef NDP_TLAST_CHECK_EN
  ,
  output logic                  proto_err
`endif
);

  localparam int c_epb       = AXIS_W / WIDTH;
  localparam int c_act_beats = ROWS / c_epb;
  localparam int c_wgt_beats = COLS / c_epb;
  localparam int c_cnt_w     = cnt_width(c_wgt_beats);

  state_t             r_state;
  logic [c_cnt_w-1:0] r_beat_cnt;
  logic [K_W-1:0]     r_vec_k;
  logic               r_vec_valid;
  logic               r_vec_last;
  logic               r_tready;

  logic w_beat;
  logic w_last_act;
  logic w_last_wgt;
  logic w_abort;
  logic w_pair_done;
  logic w_act_we;
  logic w_wgt_we;
  logic w_unused_tkeep;

  // All beats are full, so tkeep carries no information.
  assign w_unused_tkeep = s_axis_tkeep;

  assign w_beat      = s_axis_tvalid && r_tready;
  assign w_last_act  = (r_beat_cnt == c_cnt_w'(c_act_beats - 1));
  assign w_last_wgt  = (r_beat_cnt == c_cnt_w'(c_wgt_beats - 1));
  assign w_pair_done = r_vec_valid && vec_ready;

`ifdef NDP_TLAST_CHECK_EN
  logic r_proto_err;
  assign w_abort   = w_beat && s_axis_tlast && !((r_state == S_WGT) && w_last_wgt);
  assign proto_err = r_proto_err;
`else
  assign w_abort = 1'b0;
`endif

  assign w_act_we = w_beat && (r_state == S_ACT) && !w_abort;
  assign w_wgt_we = w_beat && (r_state == S_WGT) && !w_abort;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state     <= S_ACT;
      r_beat_cnt  <= '0;
      r_vec_k     <= '0;
      r_vec_valid <= 1'b0;
      r_vec_last  <= 1'b0;
      r_tready    <= 1'b0;
`ifdef NDP_TLAST_CHECK_EN
      r_proto_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_ACT, S_WGT: begin
          r_tready <= 1'b1;
          if (w_abort) begin
            r_state    <= S_ACT;
            r_beat_cnt <= '0;
            r_vec_k    <= '0;
`ifdef NDP_TLAST_CHECK_EN
            r_proto_err <= 1'b1;
`endif
          end else if (w_beat) begin
            if (r_state == S_ACT) begin
              if (w_last_act) begin
                r_beat_cnt <= '0;
                r_state    <= S_WGT;
              end else begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
              end
            end else if (w_last_wgt) begin
              r_beat_cnt  <= '0;
              r_vec_last  <= s_axis_tlast;
              r_vec_valid <= 1'b1;
              r_tready    <= 1'b0;
              r_state     <= S_HOLD;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        S_HOLD: begin
          r_tready <= w_pair_done;
          if (w_pair_done) begin
            r_vec_valid <= 1'b0;
            r_state     <= S_ACT;
            r_vec_k     <= r_vec_last ? '0 : r_vec_k + 1'b1;
          end
        end
        default: begin
          r_state  <= S_ACT;
          r_tready <= 1'b1;
        end
      endcase
    end
  end

  ndp_beat_collect #(
    .BEATS  (c_act_beats),
    .AXIS_W (AXIS_W),
    .CNT_W  (c_cnt_w)
  ) u_act_collect (
    .clk    (axi_aclk),
    .rst_n  (axi_aresetn),
    .i_we   (w_act_we),
    .i_idx  (r_beat_cnt),
    .i_data (s_axis_tdata),
    .o_vec  (act_vec)
  );

  ndp_beat_collect #(
    .BEATS  (c_wgt_beats),
    .AXIS_W (AXIS_W),
    .CNT_W  (c_cnt_w)
  ) u_wgt_collect (
    .clk    (axi_aclk),
    .rst_n  (axi_aresetn),
    .i_we   (w_wgt_we),
    .i_idx  (r_beat_cnt),
    .i_data (s_axis_tdata),
    .o_vec  (wgt_vec)
  );

  assign s_axis_tready = r_tready;
  assign vec_valid     = r_vec_valid;
  assign vec_k         = r_vec_k;
  assign vec_last      = r_vec_last;

endmodule
`default_nettype wire
